// File: rtl/line_buffer_ctrl.sv
// Sequencer for the conv-stage row-buffer chain: buffer strobes, window handshake, position and error tracking.
// Optional LINE_BUFFER_CTRL_STATS_EN adds a saturating stall_cycles counter port.
module line_buffer_ctrl #(
   parameter int IMAGE_WIDTH  = 188,
   parameter int IMAGE_HEIGHT = 120,
   parameter int KERNEL_SIZE  = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [KERNEL_SIZE-2:0]          buf_wr_en,
   output logic [KERNEL_SIZE-2:0]          buf_rd_en,
   input  logic [KERNEL_SIZE-2:0]          buf_full,
   input  logic [KERNEL_SIZE-2:0]          buf_empty,
   output logic                            win_shift,
   output logic                            win_valid,
   input  logic                            win_ready,
   output logic [$clog2(IMAGE_WIDTH)-1:0]  col,
   output logic [$clog2(IMAGE_HEIGHT)-1:0] row,
   output logic                            busy,
   output logic                            frame_done,
   output logic                            err
`ifdef LINE_BUFFER_CTRL_STATS_EN
   ,
   output logic [31:0]                     stall_cycles
`endif
);

   localparam int CW = $clog2(IMAGE_WIDTH);
   localparam int RW = $clog2(IMAGE_HEIGHT);
   localparam int NB = KERNEL_SIZE - 1;
   localparam int unsigned KM1 = KERNEL_SIZE - 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   pc_q, pc_d, col_q, col_d;
   logic [RW-1:0]   pr_q, pr_d, row_q, row_d;
   logic [NB-1:0]   fwd_q, fwd_d;
   logic            shift_q, shift_d;
   logic            wvalid_q, wvalid_d;
   logic            err_q, err_d;
   logic            accept, last_px, valid_px;
   logic [NB-1:0]   rd, wr;
`ifdef LINE_BUFFER_CTRL_STATS_EN
   logic [31:0]     stall_q, stall_d;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= '0;
         pr_q     <= '0;
         col_q    <= '0;
         row_q    <= '0;
         fwd_q    <= '0;
         shift_q  <= 1'b0;
         wvalid_q <= 1'b0;
         err_q    <= 1'b0;
`ifdef LINE_BUFFER_CTRL_STATS_EN
         stall_q  <= '0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pr_q     <= pr_d;
         col_q    <= col_d;
         row_q    <= row_d;
         fwd_q    <= fwd_d;
         shift_q  <= shift_d;
         wvalid_q <= wvalid_d;
         err_q    <= err_d;
`ifdef LINE_BUFFER_CTRL_STATS_EN
         stall_q  <= stall_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pr_d     = pr_q;
      col_d    = col_q;
      row_d    = row_q;
      wvalid_d = wvalid_q;
      err_d    = err_q;
      shift_d  = 1'b0;
`ifdef LINE_BUFFER_CTRL_STATS_EN
      stall_d  = stall_q;
`endif

      in_ready = (state_q == RUN) && !(wvalid_q && !win_ready);
      accept   = in_valid && in_ready;
      last_px  = (pc_q == COL_LAST) && (pr_q == ROW_LAST);
      valid_px = (32'(pr_q) >= KM1) && (32'(pc_q) >= KM1);

      // pc/pr track the pixel about to be accepted; buffer i is read once row i+1 starts
      rd = '0;
      for (int unsigned i = 0; i < KM1; i++) begin
         if (accept && (32'(pr_q) > i)) rd[i] = 1'b1;
      end
      // buffer 0 takes the live pixel, buffer i+1 takes what buffer i read last cycle
      wr    = NB'({fwd_q, accept});
      fwd_d = rd;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               pc_d    = '0;
               pr_d    = '0;
               col_d   = '0;
               row_d   = '0;
               err_d   = 1'b0;
`ifdef LINE_BUFFER_CTRL_STATS_EN
               stall_d = '0;
`endif
            end
         end
         RUN:     if (accept && last_px) state_d = DRAIN;
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         col_d   = pc_q;
         row_d   = pr_q;
         shift_d = 1'b1;
         if (pc_q == COL_LAST) begin
            pc_d = '0;
            pr_d = (pr_q == ROW_LAST) ? '0 : pr_q + 1'b1;
         end else begin
            pc_d = pc_q + 1'b1;
         end
      end

      if (accept && valid_px)         wvalid_d = 1'b1;
      else if (wvalid_q && win_ready) wvalid_d = 1'b0;

      if (|(wr & buf_full) || |(rd & buf_empty)) err_d = 1'b1;

`ifdef LINE_BUFFER_CTRL_STATS_EN
      if ((state_q == RUN) && in_valid && !in_ready && (stall_q != '1))
         stall_d = stall_q + 32'd1;
`endif
   end

   assign buf_wr_en  = wr;
   assign buf_rd_en  = rd;
   assign win_shift  = shift_q;
   assign win_valid  = wvalid_q;
   assign col        = col_q;
   assign row        = row_q;
   assign busy       = (state_q != IDLE);
   assign frame_done = (state_q == DONE);
   assign err        = err_q;
`ifdef LINE_BUFFER_CTRL_STATS_EN
   assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
- Sequencer for a chain of KERNEL_SIZE-1 single-row FIFO buffers, each IMAGE_WIDTH deep with a 1-cycle registered read, that forms the sliding-window front end of the CNN conv stage.
- Accepts a raster pixel stream and drives every buffer's wr_en/rd_en.
- Produces the window-register shift strobe and window-valid handshake to the MAC array.
- Tracks row/column position, frame completion and buffer overflow/underflow.

Parameters:
- IMAGE_WIDTH, 188, pixels per row; also the depth of each row buffer.
- IMAGE_HEIGHT, 120, rows per frame.
- KERNEL_SIZE, 3, window height/width; the chain uses KERNEL_SIZE-1 buffers (KERNEL_SIZE >= 2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins a frame when in IDLE
- in_valid  in  1  upstream pixel valid
- in_ready  out  1  upstream ready; a pixel is accepted when in_valid && in_ready
- buf_wr_en  out  KERNEL_SIZE-1  per-buffer write enable; buffer 0 takes the input pixel, buffer i takes buffer i-1's dout
- buf_rd_en  out  KERNEL_SIZE-1  per-buffer read enable
- buf_full  in  KERNEL_SIZE-1  per-buffer full flags
- buf_empty  in  KERNEL_SIZE-1  per-buffer empty flags
- win_shift  out  1  shift the KxK window register one column, using the new pixel plus the buffer douts
- win_valid  out  1  window register holds a complete KxK window
- win_ready  in  1  downstream accepts the window
- col  out  $clog2(IMAGE_WIDTH)  column of the most recently accepted pixel
- row  out  $clog2(IMAGE_HEIGHT)  row of the most recently accepted pixel
- busy  out  1  high in every state except IDLE
- frame_done  out  1  single-cycle pulse at end of frame
- err  out  1  sticky: a write was attempted to a full buffer or a read from an empty one

Behaviour:
- Reset (async assert, sync release): state=IDLE; col=0, row=0.
  - in_ready, buf_wr_en, buf_rd_en, win_shift, win_valid, busy, frame_done and err all 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start; col and row cleared.
  - RUN -> DRAIN on acceptance of pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1).
  - DRAIN -> DONE after 1 cycle, with the final win_shift issued.
  - DONE -> IDLE after 1 cycle, with frame_done=1.
  - start is ignored outside IDLE.
- in_ready = (state==RUN) && !(win_valid && !win_ready). Combinational; drops in the same cycle a stall appears.
- On accept at pixel (r,c), same cycle (combinational):
  - buf_wr_en[0]=1.
  - buf_rd_en[i]=1 for each i with r >= i+1.
- One cycle after accept (registered):
  - buf_wr_en[i+1]=1 for each i whose rd_en fired, so the dout just read forwards down the chain.
  - win_shift=1.
- Buffer i therefore holds row r-1-i: rows fill at row 0, read-and-forward from row 1.
- col/row update on accept: col wraps IMAGE_WIDTH-1 -> 0 and increments row; row wraps to 0 only at end of frame.
- win_valid is set in the win_shift cycle when the shifted pixel had r >= K-1 and c >= K-1.
  - Cleared on win_valid && win_ready unless a new valid shift occurs in that same cycle; then it stays 1.
  - Only valid-mode windows are produced: (W-K+1)*(H-K+1) per frame.
- Stall: while win_valid && !win_ready, no accept, so no win_shift in the following cycle; the window is held stable.
- err is set if any buf_wr_en[i] && buf_full[i], or buf_rd_en[i] && buf_empty[i]. Cleared only by reset or start.
- Reset mid-frame: all state is abandoned immediately; buffer contents are not cleared by this block, so buffer rst_n must share the same reset.

Optional Feature:
- Macro LINE_BUFFER_CTRL_STATS_EN.
- Defined: adds output stall_cycles [31:0], which counts cycles in RUN with in_valid && !in_ready.
  - Cleared on start and on reset.
  - Saturates at 2^32-1.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Use W=8, H=6, K=3. Start, then 48 back-to-back pixels with win_ready=1 -> exactly 24 win_valid cycles, the first one cycle after accepting (2,2); frame_done pulses 2 cycles after the last accept; err=0.
- Same frame with win_ready held 0 for 5 cycles at the first window -> in_ready=0 for those 5 cycles, win_valid held, no win_shift; 24 windows total.
- Accept pixel (1,0) -> buf_rd_en=2'b01 in the same cycle; buf_wr_en=2'b01 in that cycle, 2'b10 in the next.
- Force buf_full[0]=1 during an accept -> err=1 and stays 1 until the next start.
- Assert rst_n low mid-row 3 -> all outputs go to 0 asynchronously, state=IDLE; a following start runs a clean full frame.
- With LINE_BUFFER_CTRL_STATS_EN defined, hold in_valid=1 and apply a 5-cycle stall -> stall_cycles=5.
